// File: rtl/sega_pad_pkg.sv
// Shared definitions for the Sega pad scanner.
//   - scan_state_e : top-level scan FSM states
//   - BTN_*        : bit positions inside the 12-bit active-high button word
//   - DEFAULT_IDLE_TICKS : idle gap between scan frames, in sj_clk ticks
package sega_pad_pkg;

  localparam int PAD_W              = 6;
  localparam int BTN_W              = 12;
  localparam int DEFAULT_IDLE_TICKS = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Button word layout {Mode,X,Y,Z,Start,C,B,A,Right,Left,Down,Up}
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

endpackage

// File: rtl/sega_pad_scanner_sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Ports:
//   clk      : destination clock
//   reset_n  : asynchronous active-low reset (both stages load RESET_VAL)
//   i_d      : asynchronous input bus
//   o_q      : synchronized output bus
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sega_pad_scanner.sv
// Sega Mega Drive / Genesis pad scanner.
// Periodically toggles the pad SELECT line through an 8-phase frame, samples
// the (synchronized) pad lines at the end of the relevant phases and commits
// a decoded, active-high button word plus pad-type flags once per frame.
// Ports:
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   sj_clk      : poll clock, synchronous to clk; each rising edge is a tick
//   enable      : 1 = start new frames; 0 = stop at the next frame boundary
//   pad_in      : raw active-low pad lines D0..D5 (asynchronous)
//   pad_sel     : pad SELECT output
//   buttons     : {Mode,X,Y,Z,Start,C,B,A,Right,Left,Down,Up}, active-high
//   pad_present : a pad answered in the last completed frame
//   pad_6btn    : the pad identified itself as 6-button in the last frame
//   frame_done  : one-clk pulse when the outputs above are updated
module sega_pad_scanner
  import sega_pad_pkg::*;
#(
  parameter int IDLE_TICKS = DEFAULT_IDLE_TICKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sj_clk,
  input  logic             enable,
  input  logic [PAD_W-1:0] pad_in,
  output logic             pad_sel,
  output logic [BTN_W-1:0] buttons,
  output logic             pad_present,
  output logic             pad_6btn,
  output logic             frame_done
);

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TICKS - 1);

  logic [PAD_W-1:0] w_pd;
  logic             r_sj;
  logic             r_sj_prev;
  logic             w_tick;

  scan_state_e      r_state,    w_state_nxt;
  logic [2:0]       r_phase,    w_phase_nxt;
  logic [7:0]       r_idle_ctr, w_idle_nxt;
  logic             r_pad_sel,  w_pad_sel_nxt;
  logic             w_commit;

  // Only the line bits that feed the decode are kept per sample.
  logic [5:0]       r_s0;
  logic [5:2]       r_s1;
  logic [3:0]       r_s5;
  logic [3:0]       r_s6;

  logic             w_present;
  logic             w_6btn;
  logic [BTN_W-1:0] w_btn_nxt;
  logic [BTN_W-1:0] r_buttons;
  logic             r_pad_present;
  logic             r_pad_6btn;
  logic             r_frame_done;

  sync_2ff #(
    .WIDTH     (PAD_W),
    .RESET_VAL ({PAD_W{1'b1}})
  ) u_pad_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (pad_in),
    .o_q     (w_pd)
  );

  // Tick = registered sj_clk rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sj      <= 1'b0;
      r_sj_prev <= 1'b0;
    end else begin
      r_sj      <= sj_clk;
      r_sj_prev <= r_sj;
    end
  end

  assign w_tick = r_sj & ~r_sj_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_phase    <= 3'd0;
      r_idle_ctr <= 8'd0;
      r_pad_sel  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_idle_ctr <= w_idle_nxt;
      r_pad_sel  <= w_pad_sel_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_idle_nxt    = r_idle_ctr;
    w_pad_sel_nxt = r_pad_sel;
    w_commit      = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          w_pad_sel_nxt = 1'b1;
          if (r_idle_ctr == IDLE_LAST && enable) begin
            w_state_nxt = ST_SCAN;
            w_phase_nxt = 3'd0;
            w_idle_nxt  = 8'd0;
          end else if (r_idle_ctr != IDLE_LAST) begin
            w_idle_nxt = r_idle_ctr + 8'd1;
          end
        end
        ST_SCAN: begin
          if (r_phase == 3'd7) begin
            w_state_nxt   = ST_IDLE;
            w_phase_nxt   = 3'd0;
            w_idle_nxt    = 8'd0;
            w_pad_sel_nxt = 1'b1;
            w_commit      = 1'b1;
          end else begin
            w_phase_nxt   = r_phase + 3'd1;
            // Next phase is even (SELECT high) exactly when this one is odd.
            w_pad_sel_nxt = r_phase[0];
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Samples are taken on the tick that ends a phase, i.e. while the SELECT
  // level of that phase has been stable for a whole tick period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s0 <= 6'h3F;
      r_s1 <= 4'hF;
      r_s5 <= 4'hF;
      r_s6 <= 4'hF;
    end else if (w_tick && r_state == ST_SCAN) begin
      case (r_phase)
        3'd0:    r_s0 <= w_pd;
        3'd1:    r_s1 <= w_pd[5:2];
        3'd5:    r_s5 <= w_pd[3:0];
        3'd6:    r_s6 <= w_pd[3:0];
        default: ;
      endcase
    end
  end

  // A pad pulls D2/D3 low while SELECT is low; a 6-button pad additionally
  // pulls D0..D3 low in the third SELECT-low phase.
  assign w_present = ~r_s1[2] & ~r_s1[3];
  assign w_6btn    = w_present & (r_s5 == 4'b0000);

  always_comb begin
    w_btn_nxt = '0;
    if (w_present) begin
      w_btn_nxt[BTN_UP]    = ~r_s0[0];
      w_btn_nxt[BTN_DOWN]  = ~r_s0[1];
      w_btn_nxt[BTN_LEFT]  = ~r_s0[2];
      w_btn_nxt[BTN_RIGHT] = ~r_s0[3];
      w_btn_nxt[BTN_B]     = ~r_s0[4];
      w_btn_nxt[BTN_C]     = ~r_s0[5];
      w_btn_nxt[BTN_A]     = ~r_s1[4];
      w_btn_nxt[BTN_START] = ~r_s1[5];
      if (w_6btn) begin
        w_btn_nxt[BTN_Z]    = ~r_s6[0];
        w_btn_nxt[BTN_Y]    = ~r_s6[1];
        w_btn_nxt[BTN_X]    = ~r_s6[2];
        w_btn_nxt[BTN_MODE] = ~r_s6[3];
      end
    end
  end

  // All visible results change together, only on the frame-ending tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buttons     <= '0;
      r_pad_present <= 1'b0;
      r_pad_6btn    <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= w_commit;
      if (w_commit) begin
        r_buttons     <= w_btn_nxt;
        r_pad_present <= w_present;
        r_pad_6btn    <= w_6btn;
      end
    end
  end

  assign pad_sel     = r_pad_sel;
  assign buttons     = r_buttons;
  assign pad_present = r_pad_present;
  assign pad_6btn    = r_pad_6btn;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_sega_pad_scanner.sv
// Directed bench for sega_pad_scanner: a behavioural pad (none / 3-button /
// 6-button) answers the SELECT line; results are compared with hand-computed
// button words, SELECT levels and frame_done spacing.
module tb_sega_pad_scanner;
  import sega_pad_pkg::*;

  localparam longint FRAME_TIME = 64'd50400;   // 5040 clk x 10 time units

  typedef enum int {PAD_NONE, PAD_3BTN, PAD_6BTN} pad_kind_e;

  logic        clk     = 1'b0;
  logic        sj_clk  = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic [5:0]  pad_in;
  logic        pad_sel;
  logic [11:0] buttons;
  logic        pad_present;
  logic        pad_6btn;
  logic        frame_done;

  int          n_cmp  = 0;
  int          n_fail = 0;

  pad_kind_e   pad_kind = PAD_3BTN;
  logic [11:0] held     = '0;
  logic [2:0]  sel_edges;
  logic        sel_q;

  int          fd_count = 0;
  longint      fd_time  = 0;
  longint      fd_prev  = 0;

  sega_pad_scanner #(.IDLE_TICKS(64)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sj_clk      (sj_clk),
    .enable      (enable),
    .pad_in      (pad_in),
    .pad_sel     (pad_sel),
    .buttons     (buttons),
    .pad_present (pad_present),
    .pad_6btn    (pad_6btn),
    .frame_done  (frame_done)
  );

  initial forever #5 clk = ~clk;
  // 70 clk per sj_clk period; edges fall on clk falling edges.
  initial forever #350 sj_clk = ~sj_clk;

  // Pad model: the pad's internal phase is the count of SELECT transitions.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_edges <= 3'd0;
      sel_q     <= 1'b1;
    end else begin
      sel_q <= pad_sel;
      if (pad_sel !== sel_q) sel_edges <= sel_edges + 3'd1;
    end
  end

  function automatic logic [5:0] pad_lines(pad_kind_e k, logic [11:0] h, logic [2:0] e);
    logic [5:0] hi_grp;
    logic [5:0] lo_grp;
    hi_grp = {~h[BTN_C], ~h[BTN_B], ~h[BTN_RIGHT], ~h[BTN_LEFT], ~h[BTN_DOWN], ~h[BTN_UP]};
    lo_grp = {~h[BTN_START], ~h[BTN_A], 2'b00, ~h[BTN_DOWN], ~h[BTN_UP]};
    case (k)
      PAD_NONE: return 6'h3F;
      PAD_3BTN: begin
        if (e == 3'd5) return {~h[BTN_START], ~h[BTN_A], 4'b1111};
        return e[0] ? lo_grp : hi_grp;
      end
      default: begin
        if (e == 3'd5) return {~h[BTN_START], ~h[BTN_A], 4'b0000};
        if (e == 3'd6) return {~h[BTN_C], ~h[BTN_B], ~h[BTN_MODE], ~h[BTN_X], ~h[BTN_Y], ~h[BTN_Z]};
        if (e == 3'd7) return {~h[BTN_START], ~h[BTN_A], 4'b1111};
        return e[0] ? lo_grp : hi_grp;
      end
    endcase
  endfunction

  assign pad_in = pad_lines(pad_kind, held, sel_edges);

  // frame_done monitor, sampled just after the clock edge.
  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) begin
      fd_prev  <= fd_time;
      fd_time  <= $time;
      fd_count <= fd_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns 30 time units after an sj_clk rise, i.e. after the tick's update.
  task automatic wait_tick();
    @(posedge sj_clk);
    #30;
  endtask

  task automatic skip_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic wait_frame(input string tag);
    int start;
    int n;
    start = fd_count;
    n     = 0;
    while (fd_count == start && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(fd_count != start), 32'd1);
  endtask

  initial begin
    int zeros;
    int snap;

    // Reset state
    pad_kind = PAD_3BTN;
    held     = '0;
    held[BTN_A]  = 1'b1;
    held[BTN_UP] = 1'b1;
    enable   = 1'b1;
    reset_n  = 1'b0;
    #23;
    check("rst_pad_sel",     32'(pad_sel),     32'd1);
    check("rst_buttons",     32'(buttons),     32'h000);
    check("rst_pad_present", 32'(pad_present), 32'd0);
    check("rst_pad_6btn",    32'(pad_6btn),    32'd0);
    check("rst_frame_done",  32'(frame_done),  32'd0);
    @(negedge sj_clk);
    #3 reset_n = 1'b1;

    // 3-button pad, A+Up
    wait_frame("3btn_f1");
    check("3btn_buttons", 32'(buttons),     32'h011);
    check("3btn_present", 32'(pad_present), 32'd1);
    check("3btn_6btn",    32'(pad_6btn),    32'd0);

    // SELECT levels over one whole frame: idle ticks 1..63, scan ticks 64..71
    for (int t = 1; t <= 72; t++) begin
      wait_tick();
      if (t >= 64) check($sformatf("pad_sel_t%0d", t), 32'(pad_sel), (t % 2 == 0) ? 32'd1 : 32'd0);
    end
    check("3btn_f2_count",   32'(fd_count),          32'd2);
    check("3btn_f2_spacing", 32'(fd_time - fd_prev), 32'(FRAME_TIME));
    check("3btn_f2_buttons", 32'(buttons),           32'h011);

    // 6-button pad, X+Start
    pad_kind = PAD_6BTN;
    held     = '0;
    held[BTN_X]     = 1'b1;
    held[BTN_START] = 1'b1;
    wait_frame("6btn_f1");
    check("6btn_buttons", 32'(buttons),     32'h480);
    check("6btn_present", 32'(pad_present), 32'd1);
    check("6btn_6btn",    32'(pad_6btn),    32'd1);
    wait_frame("6btn_f2");
    check("6btn_spacing",    32'(fd_time - fd_prev), 32'(FRAME_TIME));
    check("6btn_f2_buttons", 32'(buttons),           32'h480);

    // Reset in the middle of a scan (phase 1, SELECT low)
    skip_ticks(65);
    check("pre_rst_pad_sel", 32'(pad_sel), 32'd0);
    #7 reset_n = 1'b0;
    #1;
    check("midrst_pad_sel",     32'(pad_sel),     32'd1);
    check("midrst_buttons",     32'(buttons),     32'h000);
    check("midrst_pad_present", 32'(pad_present), 32'd0);
    check("midrst_pad_6btn",    32'(pad_6btn),    32'd0);
    check("midrst_frame_done",  32'(frame_done),  32'd0);
    @(negedge sj_clk);
    #3 reset_n = 1'b1;
    snap  = fd_count;
    zeros = 0;
    for (int t = 1; t <= 64; t++) begin
      wait_tick();
      if (pad_sel !== 1'b1) zeros++;
    end
    check("postrst_idle_sel_low", 32'(zeros),    32'd0);
    check("postrst_no_frame",     32'(fd_count), 32'(snap));
    wait_tick();
    check("postrst_p1_sel", 32'(pad_sel), 32'd0);
    wait_frame("postrst_f1");
    check("postrst_buttons", 32'(buttons),  32'h480);
    check("postrst_6btn",    32'(pad_6btn), 32'd1);

    // No pad connected
    pad_kind = PAD_NONE;
    wait_frame("nopad_f1");
    check("nopad_present", 32'(pad_present), 32'd0);
    check("nopad_buttons", 32'(buttons),     32'h000);
    check("nopad_6btn",    32'(pad_6btn),    32'd0);
    wait_frame("nopad_f2");
    check("nopad_f2_present", 32'(pad_present), 32'd0);
    check("nopad_f2_buttons", 32'(buttons),     32'h000);

    // enable dropped during phase 3: frame finishes, then scanning stops
    pad_kind = PAD_3BTN;
    held     = '0;
    held[BTN_A]  = 1'b1;
    held[BTN_UP] = 1'b1;
    skip_ticks(67);
    check("en_p3_sel", 32'(pad_sel), 32'd0);
    enable = 1'b0;
    wait_frame("en_last_frame");
    check("en_buttons", 32'(buttons),     32'h011);
    check("en_present", 32'(pad_present), 32'd1);
    snap  = fd_count;
    zeros = 0;
    for (int t = 1; t <= 216; t++) begin
      wait_tick();
      if (pad_sel !== 1'b1) zeros++;
    end
    check("en_off_sel_low",  32'(zeros),    32'd0);
    check("en_off_no_frame", 32'(fd_count), 32'(snap));
    @(negedge sj_clk);
    enable = 1'b1;
    wait_tick();
    check("en_restart_p0_sel", 32'(pad_sel), 32'd1);
    wait_tick();
    check("en_restart_p1_sel", 32'(pad_sel), 32'd0);
    wait_frame("en_restart_frame");
    check("en_restart_buttons", 32'(buttons), 32'h011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
